// File: rtl/config_pkg.sv
// ----------------------------------------------------------------------------
// config_pkg
//   Machine-wide configuration shared by the MMU blocks.
//   XLEN : architectural register / address width.
// ----------------------------------------------------------------------------
package config_pkg;
  parameter int XLEN = 64;
endpackage : config_pkg

// File: rtl/tlb_refill_arbiter_if.sv
// ----------------------------------------------------------------------------
// tlb_refill_arbiter_if
//   Bundles every signal between the two TLBs, the shared HPTW and the refill
//   arbiter.
//   slave  : arbiter side (takes misses and walk results, drives the walk
//            request and the TLB write/fault strobes).
//   master : environment side (TLBs + HPTW), the mirror image of slave.
//   Signals:
//     ITLBMiss/DTLBMiss, ITLBVAdr/DTLBVAdr, TLBFlush    TLB -> arbiter
//     WalkReq, WalkVAdr, WalkSel                       arbiter -> HPTW
//     WalkDone, WalkFault, WalkPTE, WalkPageType       HPTW -> arbiter
//     PTE, PageTypeWriteVal, ITLBWrite, DTLBWrite,
//     IWalkFault, DWalkFault                           arbiter -> TLBs
// ----------------------------------------------------------------------------
interface tlb_refill_arbiter_if #(
  parameter int XLEN = config_pkg::XLEN
);
  logic            ITLBMiss;
  logic            DTLBMiss;
  logic [XLEN-1:0] ITLBVAdr;
  logic [XLEN-1:0] DTLBVAdr;
  logic            TLBFlush;

  logic            WalkReq;
  logic [XLEN-1:0] WalkVAdr;
  logic            WalkSel;

  logic            WalkDone;
  logic            WalkFault;
  logic [XLEN-1:0] WalkPTE;
  logic [1:0]      WalkPageType;

  logic [XLEN-1:0] PTE;
  logic [1:0]      PageTypeWriteVal;
  logic            ITLBWrite;
  logic            DTLBWrite;
  logic            IWalkFault;
  logic            DWalkFault;

  modport slave (
    input  ITLBMiss, DTLBMiss, ITLBVAdr, DTLBVAdr, TLBFlush,
    input  WalkDone, WalkFault, WalkPTE, WalkPageType,
    output WalkReq, WalkVAdr, WalkSel,
    output PTE, PageTypeWriteVal, ITLBWrite, DTLBWrite, IWalkFault, DWalkFault
  );

  modport master (
    output ITLBMiss, DTLBMiss, ITLBVAdr, DTLBVAdr, TLBFlush,
    output WalkDone, WalkFault, WalkPTE, WalkPageType,
    input  WalkReq, WalkVAdr, WalkSel,
    input  PTE, PageTypeWriteVal, ITLBWrite, DTLBWrite, IWalkFault, DWalkFault
  );
endinterface : tlb_refill_arbiter_if

// File: rtl/tlb_refill_arbiter.sv
// ----------------------------------------------------------------------------
// tlb_refill_arbiter
//   Shares one hardware page-table walker between the ITLB and the DTLB.
//   Picks a pending miss, launches a walk for its VAdr, and steers the leaf
//   PTE / page type into the owning TLB's write port. Walk faults become a
//   one-cycle fault pulse to the owner; an sfence flush abandons the walk
//   (or suppresses the pending write) so no stale entry survives.
//   Ports:
//     clk    : clock
//     reset  : synchronous, active-high reset
//     bus    : tlb_refill_arbiter_if.slave (TLB, HPTW and write-back signals)
//   Parameter:
//     STARVE_LIMIT : consecutive DTLB wins over a waiting ITLB before the
//                    ITLB is forced to win.
// ----------------------------------------------------------------------------
module tlb_refill_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  tlb_refill_arbiter_if.slave  bus
);

  localparam int XLEN     = config_pkg::XLEN;
  localparam int STREAK_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    S_IDLE,   // waiting for a miss
    S_WALK,   // HPTW busy on our behalf, WalkReq high
    S_WRITE,  // result registered, strobing the owner's write port
    S_ABORT   // flushed mid-walk, draining the HPTW's completion
  } state_e;

  state_e                r_state;
  state_e                w_state_nxt;
  logic [XLEN-1:0]       r_walk_vadr;
  logic                  r_walk_sel;     // 1 = ITLB owns the walk
  logic [XLEN-1:0]       r_pte;
  logic [1:0]            r_page_type;
  logic                  r_ifault;
  logic                  r_dfault;
  logic [STREAK_W-1:0]   r_dstreak;      // DTLB wins while ITLB was waiting

  logic                  w_grant;
  logic                  w_grant_i;
  logic                  w_capture;
  logic                  w_ifault_nxt;
  logic                  w_dfault_nxt;
  logic [STREAK_W-1:0]   w_dstreak_nxt;

  // NOTE: every signal driven here gets a default before the case statement;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    w_state_nxt   = r_state;
    w_grant       = 1'b0;
    w_grant_i     = 1'b0;
    w_capture     = 1'b0;
    w_ifault_nxt  = 1'b0;
    w_dfault_nxt  = 1'b0;
    w_dstreak_nxt = r_dstreak;

    unique case (r_state)
      S_IDLE: begin
        // A flush cycle never grants: the requester's VAdr may belong to
        // the translation context being torn down.
        if (!bus.TLBFlush && (bus.ITLBMiss || bus.DTLBMiss)) begin
          w_grant     = 1'b1;
          // DTLB wins ties until it has starved the ITLB STARVE_LIMIT times.
          w_grant_i   = bus.ITLBMiss && (!bus.DTLBMiss || (r_dstreak == STREAK_MAX));
          w_state_nxt = S_WALK;
        end
      end

      S_WALK: begin
        if (bus.TLBFlush) begin
          // A completion in the flush cycle is simply dropped; otherwise
          // the HPTW still owes us a WalkDone that must be drained.
          w_state_nxt = bus.WalkDone ? S_IDLE : S_ABORT;
        end else if (bus.WalkDone) begin
          if (bus.WalkFault) begin
            w_ifault_nxt = r_walk_sel;
            w_dfault_nxt = !r_walk_sel;
            w_state_nxt  = S_IDLE;
          end else begin
            w_capture    = 1'b1;
            w_state_nxt  = S_WRITE;
          end
        end
      end

      S_WRITE: w_state_nxt = S_IDLE;

      S_ABORT: begin
        if (bus.WalkDone) w_state_nxt = S_IDLE;
      end

      default: w_state_nxt = S_IDLE;
    endcase

    // Starvation counter only moves on a grant; it cannot exceed the limit
    // because at the limit a waiting ITLB always wins and clears it.
    if (w_grant) begin
      if (w_grant_i || !bus.ITLBMiss) begin
        w_dstreak_nxt = '0;
      end else if (r_dstreak != STREAK_MAX) begin
        w_dstreak_nxt = r_dstreak + STREAK_W'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_walk_vadr <= '0;
      r_walk_sel  <= 1'b0;
      r_pte       <= '0;
      r_page_type <= '0;
      r_ifault    <= 1'b0;
      r_dfault    <= 1'b0;
      r_dstreak   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_dstreak   <= w_dstreak_nxt;
      r_ifault    <= w_ifault_nxt;
      r_dfault    <= w_dfault_nxt;
      if (w_grant) begin
        r_walk_vadr <= w_grant_i ? bus.ITLBVAdr : bus.DTLBVAdr;
        r_walk_sel  <= w_grant_i;
      end
      if (w_capture) begin
        r_pte       <= bus.WalkPTE;
        r_page_type <= bus.WalkPageType;
      end
    end
  end

  assign bus.WalkReq          = (r_state == S_WALK);
  assign bus.WalkVAdr         = r_walk_vadr;
  assign bus.WalkSel          = r_walk_sel;
  assign bus.PTE              = r_pte;
  assign bus.PageTypeWriteVal = r_page_type;
  // A flush arriving in the write cycle must kill the strobe, so the write
  // enables stay combinational on TLBFlush.
  assign bus.ITLBWrite        = (r_state == S_WRITE) &&  r_walk_sel && !bus.TLBFlush;
  assign bus.DTLBWrite        = (r_state == S_WRITE) && !r_walk_sel && !bus.TLBFlush;
  assign bus.IWalkFault       = r_ifault;
  assign bus.DWalkFault       = r_dfault;

endmodule : tlb_refill_arbiter
